// File: rtl/recog_result_scheduler_if.sv
// Calculator request/acknowledge channel: scheduler issues operands, calculator acknowledges.
interface recog_result_scheduler_if;
  logic       calc_req;
  logic       calc_ack;
  logic [3:0] calc_num1;
  logic [3:0] calc_op;
  logic [3:0] calc_num2;

  modport master (
    output calc_req,
    output calc_num1,
    output calc_op,
    output calc_num2,
    input  calc_ack
  );

  modport slave (
    input  calc_req,
    input  calc_num1,
    input  calc_op,
    input  calc_num2,
    output calc_ack
  );
endinterface

// File: rtl/recog_result_scheduler.sv
// Debounces recognised digit/operator triples across frames and issues stable expressions
// to the calculator, holding the result-valid/blank state for the overlay.
module recog_result_scheduler #(
  parameter int unsigned STABLE_FRAMES  = 4,
  parameter int unsigned TIMEOUT_FRAMES = 60,
  parameter bit          VS_POL         = 1'b1
) (
  input  logic                            clk_Image_Process,
  input  logic                            Rst,
  input  logic                            enable,
  input  logic                            RGB_VSync_Src,
  input  logic                            RGB_VDE_Src,
  input  logic [3:0]                      num1_in,
  input  logic [3:0]                      num2_in,
  input  logic [3:0]                      num3_in,
  recog_result_scheduler_if.master        calc,
  output logic                            result_valid,
  output logic                            disp_blank,
  output logic [2:0]                      stable_cnt
);

  localparam logic [2:0] StableMax  = 3'(STABLE_FRAMES);
  localparam logic [7:0] TimeoutMax = 8'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {StIdle, StSample, StCompare, StIssue} state_e;

  state_e     state_q;
  logic       vs_d_q;
  logic       frame_seen_q;
  logic [3:0] cand1_q, cand_op_q, cand2_q;
  logic [7:0] miss_q;
  logic       calc_req_q;
  logic [3:0] calc_num1_q, calc_op_q, calc_num2_q;
  logic       result_valid_q;
  logic [2:0] stable_cnt_q;

  logic       tick, counted, in_valid, in_same, cand_new;
  logic [7:0] miss_inc;

  assign tick     = (RGB_VSync_Src == VS_POL) && (vs_d_q != VS_POL);
  // Ticks closing a frame with no active video carry no recognition data.
  assign counted  = tick && frame_seen_q;
  assign in_valid = (num1_in <= 4'd9) && (num2_in >= 4'd10) && (num2_in <= 4'd13) &&
                    (num3_in <= 4'd9);
  assign in_same  = {num1_in, num2_in, num3_in} == {cand1_q, cand_op_q, cand2_q};
  assign cand_new = {cand1_q, cand_op_q, cand2_q} != {calc_num1_q, calc_op_q, calc_num2_q};
  assign miss_inc = (miss_q < TimeoutMax) ? miss_q + 8'd1 : miss_q;

  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      state_q        <= StIdle;
      vs_d_q         <= 1'b0;
      frame_seen_q   <= 1'b0;
      cand1_q        <= 4'd15;
      cand_op_q      <= 4'd15;
      cand2_q        <= 4'd15;
      miss_q         <= 8'd0;
      calc_req_q     <= 1'b0;
      calc_num1_q    <= 4'd0;
      calc_op_q      <= 4'd0;
      calc_num2_q    <= 4'd0;
      result_valid_q <= 1'b0;
      stable_cnt_q   <= 3'd0;
    end else begin
      vs_d_q <= RGB_VSync_Src;
      if (tick) begin
        frame_seen_q <= RGB_VDE_Src;
      end else if (RGB_VDE_Src) begin
        frame_seen_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          cand1_q        <= 4'd15;
          cand_op_q      <= 4'd15;
          cand2_q        <= 4'd15;
          miss_q         <= 8'd0;
          calc_req_q     <= 1'b0;
          calc_num1_q    <= 4'd0;
          calc_op_q      <= 4'd0;
          calc_num2_q    <= 4'd0;
          result_valid_q <= 1'b0;
          stable_cnt_q   <= 3'd0;
          if (enable) state_q <= StSample;
        end
        StSample: begin
          if (!enable) begin
            state_q <= StIdle;
          end else if (counted) begin
            cand1_q   <= num1_in;
            cand_op_q <= num2_in;
            cand2_q   <= num3_in;
            if (in_valid) begin
              miss_q <= 8'd0;
              if (!in_same) stable_cnt_q <= 3'd1;
              else if (stable_cnt_q < StableMax) stable_cnt_q <= stable_cnt_q + 3'd1;
            end else begin
              stable_cnt_q <= 3'd0;
              miss_q       <= miss_inc;
              if (miss_inc >= TimeoutMax) result_valid_q <= 1'b0;
            end
            state_q <= StCompare;
          end
        end
        StCompare: begin
          if (stable_cnt_q == StableMax && (!result_valid_q || cand_new)) begin
            calc_req_q  <= 1'b1;
            calc_num1_q <= cand1_q;
            calc_op_q   <= cand_op_q;
            calc_num2_q <= cand2_q;
            state_q     <= StIssue;
          end else begin
            state_q <= StSample;
          end
        end
        StIssue: begin
          // Timeout keeps running while the calculator stalls; the ack below takes priority.
          if (counted) begin
            if (in_valid) begin
              miss_q <= 8'd0;
            end else begin
              miss_q <= miss_inc;
              if (miss_inc >= TimeoutMax) result_valid_q <= 1'b0;
            end
          end
          if (calc_req_q && calc.calc_ack) begin
            calc_req_q     <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= enable ? StSample : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign calc.calc_req  = calc_req_q;
  assign calc.calc_num1 = calc_num1_q;
  assign calc.calc_op   = calc_op_q;
  assign calc.calc_num2 = calc_num2_q;
  assign result_valid   = result_valid_q;
  assign disp_blank     = ~result_valid_q;
  assign stable_cnt     = stable_cnt_q;

endmodule

// File: tb/tb_recog_result_scheduler.sv
// Directed bench for recog_result_scheduler: frame vector table plus hand-written sequences.
module tb_recog_result_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       vs;
  logic       vde;
  logic [3:0] n1, n2, n3;
  logic       result_valid, disp_blank;
  logic [2:0] stable_cnt;

  int checks   = 0;
  int failures = 0;
  int req_cycles = 0;

  recog_result_scheduler_if calc_if ();

  recog_result_scheduler dut (
    .clk_Image_Process (clk),
    .Rst               (rst_n),
    .enable            (enable),
    .RGB_VSync_Src     (vs),
    .RGB_VDE_Src       (vde),
    .num1_in           (n1),
    .num2_in           (n2),
    .num3_in           (n3),
    .calc              (calc_if),
    .result_valid      (result_valid),
    .disp_blank        (disp_blank),
    .stable_cnt        (stable_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (calc_if.calc_req) req_cycles++;

  typedef struct packed {
    logic       do_rst;
    logic [3:0] a, op, b;
    logic       vde;
    logic [2:0] exp_stable;
    logic       exp_req;
    logic       exp_rv;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset(input logic ack);
    rst_n = 1'b0;
    enable = 1'b1;
    vs = 1'b0;
    vde = 1'b0;
    n1 = 4'd15; n2 = 4'd15; n3 = 4'd15;
    calc_if.calc_ack = ack;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Ends one cycle after the capturing edge (state is then COMPARE).
  task automatic send_frame(input logic [3:0] a, op, b, input logic v);
    n1 = a; n2 = op; n3 = b;
    vs = 1'b0;
    vde = v;
    step(2);
    vde = 1'b0;
    step(1);
    vs = 1'b1;
    step(1);
  endtask

  task automatic frames(input logic [3:0] a, op, b, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      send_frame(a, op, b, 1'b1);
      step(2);
    end
  endtask

  initial begin
    int base;
    int bad;

    // Scenario 1
    vecs.push_back({1'b1, 4'd3, 4'd10, 4'd5, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd10, 4'd5, 1'b1, 3'd2, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd10, 4'd5, 1'b1, 3'd3, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd10, 4'd5, 1'b1, 3'd4, 1'b1, 1'b1});
    // Scenario 2
    vecs.push_back({1'b1, 4'd3, 4'd10, 4'd5, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd10, 4'd5, 1'b1, 3'd2, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd11, 4'd5, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd11, 4'd5, 1'b1, 3'd2, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd11, 4'd5, 1'b1, 3'd3, 1'b0, 1'b0});
    vecs.push_back({1'b0, 4'd3, 4'd11, 4'd5, 1'b1, 3'd4, 1'b1, 1'b1});
    // Scenario 4: ticks without active video are ignored, then normal frames resume
    vecs.push_back({1'b0, 4'd15, 4'd15, 4'd15, 1'b0, 3'd4, 1'b0, 1'b1});
    vecs.push_back({1'b0, 4'd9, 4'd13, 4'd9, 1'b0, 3'd4, 1'b0, 1'b1});
    vecs.push_back({1'b0, 4'd3, 4'd11, 4'd5, 1'b1, 3'd4, 1'b0, 1'b1});
    vecs.push_back({1'b0, 4'd15, 4'd15, 4'd15, 1'b1, 3'd0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 4'd3, 4'd11, 4'd5, 1'b1, 3'd1, 1'b0, 1'b1});

    // Reset state, sampled while reset is held
    rst_n = 1'b0;
    enable = 1'b1;
    vs = 1'b0; vde = 1'b0;
    n1 = 4'd15; n2 = 4'd15; n3 = 4'd15;
    calc_if.calc_ack = 1'b1;
    step(2);
    check("rst_req", 8'(calc_if.calc_req), 8'd0);
    check("rst_num1", 8'(calc_if.calc_num1), 8'd0);
    check("rst_op", 8'(calc_if.calc_op), 8'd0);
    check("rst_num2", 8'(calc_if.calc_num2), 8'd0);
    check("rst_rv", 8'(result_valid), 8'd0);
    check("rst_blank", 8'(disp_blank), 8'd1);
    check("rst_stable", 8'(stable_cnt), 8'd0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) apply_reset(1'b1);
      send_frame(vecs[i].a, vecs[i].op, vecs[i].b, vecs[i].vde);
      check($sformatf("vec%0d_stable", i), 8'(stable_cnt), 8'(vecs[i].exp_stable));
      step(1);
      check($sformatf("vec%0d_req", i), 8'(calc_if.calc_req), 8'(vecs[i].exp_req));
      if (vecs[i].exp_req) begin
        check($sformatf("vec%0d_num1", i), 8'(calc_if.calc_num1), 8'(vecs[i].a));
        check($sformatf("vec%0d_op", i), 8'(calc_if.calc_op), 8'(vecs[i].op));
        check($sformatf("vec%0d_num2", i), 8'(calc_if.calc_num2), 8'(vecs[i].b));
      end
      step(1);
      check($sformatf("vec%0d_req_low", i), 8'(calc_if.calc_req), 8'd0);
      check($sformatf("vec%0d_rv", i), 8'(result_valid), 8'(vecs[i].exp_rv));
      check($sformatf("vec%0d_blank", i), 8'(disp_blank), 8'(!vecs[i].exp_rv));
    end

    // Scenario 3: no re-issue while held, timeout, then re-issue
    apply_reset(1'b1);
    base = req_cycles;
    frames(4'd7, 4'd12, 4'd2, 4);
    check("s3_first_issue", 8'(req_cycles - base), 8'd1);
    check("s3_num1", 8'(calc_if.calc_num1), 8'd7);
    check("s3_op", 8'(calc_if.calc_op), 8'd12);
    check("s3_num2", 8'(calc_if.calc_num2), 8'd2);
    base = req_cycles;
    frames(4'd7, 4'd12, 4'd2, 20);
    check("s3_no_reissue", 8'(req_cycles - base), 8'd0);
    frames(4'd15, 4'd15, 4'd15, 59);
    check("s3_rv_before_timeout", 8'(result_valid), 8'd1);
    send_frame(4'd15, 4'd15, 4'd15, 1'b1);
    check("s3_rv_at_timeout", 8'(result_valid), 8'd0);
    check("s3_blank_at_timeout", 8'(disp_blank), 8'd1);
    step(2);
    base = req_cycles;
    frames(4'd7, 4'd12, 4'd2, 4);
    check("s3_reissue", 8'(req_cycles - base), 8'd1);
    check("s3_rv_after_reissue", 8'(result_valid), 8'd1);

    // Scenario 5: withheld ack with enable dropped and inputs changing
    apply_reset(1'b0);
    frames(4'd3, 4'd10, 4'd5, 3);
    send_frame(4'd3, 4'd10, 4'd5, 1'b1);
    step(1);
    check("s5_req", 8'(calc_if.calc_req), 8'd1);
    enable = 1'b0;
    n1 = 4'd9; n2 = 4'd13; n3 = 4'd8;
    bad = 0;
    repeat (10) begin
      step(1);
      if (!(calc_if.calc_req === 1'b1 && calc_if.calc_num1 === 4'd3 &&
            calc_if.calc_op === 4'd10 && calc_if.calc_num2 === 4'd5)) bad++;
    end
    check("s5_held_cycles_bad", 8'(bad), 8'd0);
    calc_if.calc_ack = 1'b1;
    step(1);
    calc_if.calc_ack = 1'b0;
    check("s5_req_after_ack", 8'(calc_if.calc_req), 8'd0);
    check("s5_rv_after_ack", 8'(result_valid), 8'd1);
    check("s5_stable_kept", 8'(stable_cnt), 8'd4);
    check("s5_state_idle", 8'(dut.state_q), 8'd0);

    // Scenario 6: asynchronous reset during a pending request
    apply_reset(1'b0);
    frames(4'd3, 4'd10, 4'd5, 3);
    send_frame(4'd3, 4'd10, 4'd5, 1'b1);
    step(1);
    check("s6_req", 8'(calc_if.calc_req), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_req_async", 8'(calc_if.calc_req), 8'd0);
    check("s6_num1", 8'(calc_if.calc_num1), 8'd0);
    check("s6_op", 8'(calc_if.calc_op), 8'd0);
    check("s6_num2", 8'(calc_if.calc_num2), 8'd0);
    check("s6_rv", 8'(result_valid), 8'd0);
    check("s6_blank", 8'(disp_blank), 8'd1);
    check("s6_stable", 8'(stable_cnt), 8'd0);
    step(1);
    rst_n = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
